cyq_seq_det: RTL



---
 rtl/cyq_det_pkg.sv | 17 +
 rtl/cyq_sat_cnt.sv | 24 ++
 rtl/cyq_seq_det.sv | 75 +++++++
 3 files changed

// File: rtl/cyq_det_pkg.sv
// Shared constants and helpers for the serial pattern detector family.
// Defaults match the lab's 4-bit 1011 detector with an 8-bit match counter.
package cyq_det_pkg;

  localparam int unsigned DEF_PAT_W   = 4;
  localparam logic [3:0]  DEF_PATTERN = 4'b1011;
  localparam int unsigned DEF_CNT_W   = 8;

  // Fill occupancy endpoints; ARMED equals the pattern length in use.
  localparam int unsigned FILL_EMPTY  = 0;
  localparam int unsigned FILL_ARMED  = DEF_PAT_W;

  function automatic int unsigned fill_width(input int unsigned pat_w);
    return $clog2(pat_w + 1);
  endfunction

endpackage

// File: rtl/cyq_sat_cnt.sv
// Saturating up-counter: clears synchronously, increments on en & inc,
// and holds at all-ones instead of wrapping.
module cyq_sat_cnt #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && inc && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/cyq_seq_det.sv
// Parametrised serial pattern detector with a registered hit pulse,
// run-time overlap selection and a saturating match count.
//
// fill state  | meaning
// 0..PAT_W-1  | FILLING: window not yet fully populated since clear/match
// PAT_W       | ARMED: any fresh bit can complete a match
module cyq_seq_det
  import cyq_det_pkg::*;
#(
  parameter int unsigned      PAT_W   = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PATTERN = PAT_W'(DEF_PATTERN),
  parameter int unsigned      CNT_W   = DEF_CNT_W
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              en,
  input  logic                              din,
  input  logic                              overlap,
  input  logic                              clr,
  output logic                              y,
  output logic [CNT_W-1:0]                  cnt,
  output logic [fill_width(PAT_W)-1:0]      fill
);

  localparam int unsigned      FW        = fill_width(PAT_W);
  localparam logic [FW-1:0]    F_EMPTY   = FW'(FILL_EMPTY);
  localparam logic [FW-1:0]    F_ARMED   = FW'(PAT_W);
  localparam logic [FW-1:0]    F_PRE_ARM = FW'(PAT_W - 1);

  // Only PAT_W-1 bits of history are kept; din supplies the newest bit.
  logic [PAT_W-2:0] hist;
  logic [PAT_W-1:0] window;
  logic             match;
  logic [FW-1:0]    fill_nxt;

  always_comb begin
    window   = {hist, din};
    match    = en && !clr && (fill >= F_PRE_ARM) && (window == PATTERN);
    fill_nxt = (fill == F_ARMED) ? F_ARMED : fill + FW'(1);
    // Non-overlap restarts occupancy so PAT_W fresh bits are needed again.
    if (match && !overlap) begin
      fill_nxt = F_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist <= '0;
      fill <= F_EMPTY;
      y    <= 1'b0;
    end else if (clr) begin
      hist <= '0;
      fill <= F_EMPTY;
      y    <= 1'b0;
    end else if (en) begin
      hist <= window[PAT_W-2:0];
      fill <= fill_nxt;
      y    <= match;
    end else begin
      y    <= 1'b0;
    end
  end

  cyq_sat_cnt #(
    .W(CNT_W)
  ) u_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr),
    .en   (en),
    .inc  (match),
    .cnt  (cnt)
  );

endmodule
